ahbslave: RTL
=============

# ahbslave

AHB-Lite responder (slave) with 8-bit on-chip memory, the completion side of the team's AHB master and address decoder/multiplexor fabric. One instance sits behind each `hsel_x` line and drives that slot's `hrdata_x`/`hreadyout_x`/`hresp_x`. It supports programmable wait states and returns a two-cycle ERROR for out-of-range addresses.

## Interface
- `DEPTH`, 256: number of 8-bit words; legal addresses are 0..DEPTH-1 (DEPTH ≤ 1024).
- `WAIT_STATES`, 0: wait cycles inserted in every OKAY data phase (0..15).

- `hclk` input 1: the only clock; all state changes on its rising edge.
- `hresetn` input 1: asynchronous, active-low reset.
- `hsel` input 1: slave select from the decoder.
- `haddr` input 10: byte address.
- `hwrite` input 1: 1 = write, 0 = read.
- `htrans` input 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hburst` input 3: accepted, ignored (master supplies every address).
- `hsize` input 3: accepted, ignored (byte transfers only).
- `hwdata` input 8: write data, valid in the write data phase.
- `hready` input 1: bus-level ready (the selected slave's `hreadyout`).
- `hrdata` output 8: read data.
- `hreadyout` output 1: 0 extends the current data phase.
- `hresp` output 1: 0 OKAY, 1 ERROR.

## Operation
- Accept condition at a rising edge: `hsel & hready & htrans[1]`. On accept, register `haddr`, `hwrite`, and `err = (haddr >= DEPTH)`.
- IDLE/BUSY transfers and `hsel`=0 are never accepted. They produce zero-wait OKAY: `hreadyout`=1, `hresp`=0.
- FSM states:
  - ST_IDLE: `hreadyout`=1, `hresp`=0.
  - ST_WAIT: `hreadyout`=0, `hresp`=0.
  - ST_LAST: `hreadyout`=1, `hresp`=0; this is the transfer-completion cycle.
  - ST_ERR1: `hreadyout`=0, `hresp`=1.
  - ST_ERR2: `hreadyout`=1, `hresp`=1.
- Transitions on accept (legal from ST_IDLE, ST_LAST, ST_ERR2):
  - `err` → ST_ERR1.
  - Otherwise, WAIT_STATES>0 → ST_WAIT with counter loaded to WAIT_STATES.
  - Otherwise → ST_LAST.
- ST_WAIT: decrement the counter each cycle; move to ST_LAST on the cycle the counter reaches 1.
- ST_ERR1 → ST_ERR2 unconditionally.
- ST_LAST or ST_ERR2 with no accept → ST_IDLE.
- ST_WAIT and ST_ERR1 ignore the bus; `hready`=0 prevents accepts.
- Write: `hwdata` is sampled at the edge that ends ST_LAST. `mem[addr_q]` is updated at that same edge.
- Read: `hrdata` is registered. It is loaded with `mem[addr_q]` on entry to ST_LAST and held until the next read completes.
- Read-after-write forwarding: a read of address A may be accepted at the edge that commits a write to A. If that read enters ST_LAST at the same edge (WAIT_STATES=0), it must return the just-written `hwdata`.
- Errored transfers: no memory write; `hrdata` is loaded with 0x00. Wait states never apply to ERROR responses.
- Memory contents are not reset.

## Timing
- Reset values (asynchronous): state ST_IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0x00, counter 0.
- Reset asserted mid-transfer: the transfer is dropped, no memory write occurs, and outputs return to reset values immediately.
- OKAY data phase: WAIT_STATES+1 cycles after the accept edge. `hreadyout` is low for the first WAIT_STATES cycles and high in the last.
- ERROR data phase: exactly 2 cycles, (0,1) then (1,1) for (`hreadyout`,`hresp`).
- Pipelining: the next address phase may be accepted in ST_LAST or ST_ERR2. Back-to-back transfers at WAIT_STATES=0 complete one per cycle.
- Read latency: data is valid in ST_LAST, i.e. 1 cycle after the accept edge when WAIT_STATES=0.
- Address decoding uses all 10 bits; there is no wrap-around. For example, 0x100 with DEPTH=256 is an ERROR, not an alias of 0x000.

## Test plan
- Reset: hold `hresetn`=0 → `hreadyout`=1, `hresp`=0, `hrdata`=0x00; IDLE/BUSY traffic afterwards keeps `hreadyout`=1, `hresp`=0.
- WAIT_STATES=0: NONSEQ write 0xA5 to 0x005, then a later NONSEQ read of 0x005 → `hrdata`=0xA5 one cycle after the read accept; `hreadyout` never drops.
- WAIT_STATES=2: read of 0x010 (preloaded 0x3C) → `hreadyout`=0 for 2 cycles, then 1 with `hrdata`=0x3C and `hresp`=0.
- WAIT_STATES=0 pipelined: write 0x77 to 0x003 followed immediately by a read of 0x003 → read returns 0x77 (forwarding); next write/read pairs to 0x004..0x006 complete one per cycle.
- DEPTH=256: write 0x55 to 0x300 → (`hreadyout`,`hresp`)=(0,1) then (1,1); then a read of 0x000 returns its prior value and `hresp` is back to 0.
- WAIT_STATES=3: write 0x99 to 0x020, assert `hresetn`=0 during the second wait cycle → `hreadyout`=1 immediately; after release, a read of 0x020 returns the old value, not 0x99.

Source files
------------

// File: rtl/ahbslave.sv
// rtl/ahbslave.sv - AHB-Lite responder with byte memory, programmable wait states and two-cycle ERROR.
module ahbslave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hsel,
    input  logic [9:0] haddr,
    input  logic       hwrite,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic [2:0] hsize,
    input  logic [7:0] hwdata,
    input  logic       hready,
    output logic [7:0] hrdata,
    output logic       hreadyout,
    output logic       hresp
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_L = 11'(DEPTH);
    localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;

    state_t     state, state_nxt;
    logic [9:0] addr_q;
    logic       write_q;
    logic [3:0] cnt;
    logic [7:0] mem [0:DEPTH-1];

    logic       accept, addr_err, commit, rd_is_read;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       unused;

    assign unused = ^{hburst, hsize};

    assign accept   = (state == ST_IDLE || state == ST_LAST || state == ST_ERR2)
                      && hsel && hready && htrans[1];
    assign addr_err = {1'b0, haddr} >= DEPTH_L;
    assign commit   = (state == ST_LAST) && write_q;

    // A read reaches ST_LAST either straight from its accept or after waiting.
    assign rd_addr    = (state == ST_WAIT) ? addr_q : haddr;
    assign rd_is_read = (state == ST_WAIT) ? !write_q : !hwrite;
    assign rd_data    = (commit && addr_q == rd_addr) ? hwdata : mem[rd_addr[AW-1:0]];

    always_comb begin
        state_nxt = state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 4'd1) state_nxt = ST_LAST;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: begin
                hresp = (state == ST_ERR2);
                if (!accept)            state_nxt = ST_IDLE;
                else if (addr_err)      state_nxt = ST_ERR1;
                else if (WS_L != 4'd0)  state_nxt = ST_WAIT;
                else                    state_nxt = ST_LAST;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt     <= '0;
            hrdata  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
            end
            if (accept && !addr_err && WS_L != 4'd0)
                cnt <= WS_L;
            else if (state == ST_WAIT)
                cnt <= cnt - 4'd1;
            if (state_nxt == ST_LAST && rd_is_read)
                hrdata <= rd_data;
            else if (state_nxt == ST_ERR1)
                hrdata <= 8'h00;
        end
    end

    // Memory is deliberately not reset; writes land only when a write leaves ST_LAST.
    always_ff @(posedge hclk) begin
        if (commit) mem[addr_q[AW-1:0]] <= hwdata;
    end
endmodule
